// File: rtl/mem_pkg.sv
// Shared definitions for the handshaked MIPS memory-access stage.
package mem_pkg;

  // Memory op codes (any other aluop value is a non-memory op)
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_SC  = 8'hF8;

  // Exception codes reported on exc_o
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Registered write-side bus payload, held stable while in BUS
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_lanes_t;

  // Access size of an op; SZ_NONE marks a non-memory op
  function automatic size_t op_size(input logic [7:0] op);
    size_t sz;
    sz = SZ_NONE;
    case (op)
      OP_LB, OP_LBU, OP_SB:        sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH:        sz = SZ_HALF;
      OP_LW, OP_LL, OP_SW, OP_SC:  sz = SZ_WORD;
      default:                     sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  // Byte enables for an access; little-endian map, mirrored for big-endian
  function automatic logic [3:0] lane_sel(input size_t sz, input logic [1:0] off,
                                          input logic big_endian);
    logic [3:0] s;
    s = 4'b0000;
    case (sz)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    if (big_endian) s = {s[0], s[1], s[2], s[3]};
    return s;
  endfunction

endpackage

// File: rtl/mem_stage_hs_lane_fmt.sv
// Lane steering: byte enables, store replication, load extraction/extension, misalignment.
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [7:0]  aluop,
  input  logic [1:0]  off,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  size_t      sz;
  logic [1:0] boff;
  logic       hsel;
  logic [7:0] byte_v;
  logic [15:0] half_v;

  // Combinational lane formatting for both directions
  always_comb begin
    sz       = op_size(aluop);
    sel      = lane_sel(sz, off, BIG_ENDIAN);
    boff     = BIG_ENDIAN ? ~off : off;
    hsel     = BIG_ENDIAN ? ~off[1] : off[1];
    byte_v   = rdata[{boff, 3'b000} +: 8];
    half_v   = hsel ? rdata[31:16] : rdata[15:0];
    wdata    = reg2;
    ldata    = 32'h0;
    misalign = 1'b0;
    case (sz)
      SZ_BYTE: wdata = {4{reg2[7:0]}};
      SZ_HALF: wdata = {2{reg2[15:0]}};
      default: wdata = reg2;
    endcase
    case (aluop)
      OP_LB:        ldata = {{24{byte_v[7]}}, byte_v};
      OP_LBU:       ldata = {24'h0, byte_v};
      OP_LH:        ldata = {{16{half_v[15]}}, half_v};
      OP_LHU:       ldata = {16'h0, half_v};
      OP_LW, OP_LL: ldata = rdata;
      default:      ldata = 32'h0;
    endcase
    case (sz)
      SZ_HALF: misalign = off[0];
      SZ_WORD: misalign = (off != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS MEM stage with a req/ack data-bus handshake, LL/SC link bit and bus timeout.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              llbit_clr_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic [1:0]        exc_o,
  output logic              llbit_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  logic [7:0]        r_aluop;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_wd;
  logic              r_wreg;
  bus_lanes_t        r_lanes;
  logic [31:0]       r_rdata;
  logic              r_flushed;
  logic              r_tmo;
  logic [CNT_W-1:0]  cnt;
  logic              llbit;

  logic [7:0]  fmt_op;
  logic [1:0]  fmt_off;
  logic [3:0]  fmt_sel;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ldata;
  logic        fmt_misalign;

  logic is_mem;
  logic sc_fail;
  logic accept;
  logic tmo_hit;
  logic kill;

  // Formatter sees live inputs while idle, the latched request afterwards
  assign fmt_op  = (state == ST_IDLE) ? aluop_i : r_aluop;
  assign fmt_off = (state == ST_IDLE) ? addr_i[1:0] : r_addr[1:0];

  mem_lane_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
    .aluop    (fmt_op),
    .off      (fmt_off),
    .reg2     (reg2_i),
    .rdata    (r_rdata),
    .sel      (fmt_sel),
    .wdata    (fmt_wdata),
    .ldata    (fmt_ldata),
    .misalign (fmt_misalign)
  );

  // Request decode in IDLE and bus-cycle events
  assign is_mem  = (op_size(aluop_i) != SZ_NONE);
  assign sc_fail = (aluop_i == OP_SC) && !llbit;
  assign accept  = valid_i && !flush_i && is_mem && !fmt_misalign && !sc_fail;
  assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign kill    = r_flushed || flush_i;
  assign llbit_o = llbit;

  // State, latched request, timeout counter and link bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      r_aluop   <= 8'h0;
      r_addr    <= '0;
      r_wd      <= 5'h0;
      r_wreg    <= 1'b0;
      r_lanes   <= '0;
      r_rdata   <= 32'h0;
      r_flushed <= 1'b0;
      r_tmo     <= 1'b0;
      cnt       <= '0;
      llbit     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_aluop   <= aluop_i;
            r_addr    <= addr_i;
            r_wd      <= wd_i;
            r_wreg    <= wreg_i;
            r_lanes   <= '{we: op_is_store(aluop_i), sel: fmt_sel, wdata: fmt_wdata};
            r_flushed <= 1'b0;
            r_tmo     <= 1'b0;
            cnt       <= '0;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (flush_i) r_flushed <= 1'b1;
          if (bus_ack_i) begin
            r_rdata <= bus_rdata_i;
            state   <= ST_DONE;
          end else if (tmo_hit) begin
            r_tmo <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (llbit_clr_i) begin
        llbit <= 1'b0;
      end else if (state == ST_BUS && bus_ack_i && !kill) begin
        if (r_aluop == OP_LL)      llbit <= 1'b1;
        else if (r_aluop == OP_SC) llbit <= 1'b0;
      end
    end
  end

  // Outputs: zero-latency pass-through in IDLE, register-driven in BUS/DONE
  always_comb begin
    wd_o        = 5'h0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0;
    stall_req_o = 1'b0;
    exc_o       = EXC_NONE;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_sel_o   = 4'h0;
    bus_wdata_o = 32'h0;
    case (state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (!is_mem) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (fmt_misalign) begin
            wd_o  = wd_i;
            exc_o = op_is_store(aluop_i) ? EXC_ADES : EXC_ADEL;
          end else if (sc_fail) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
          end else begin
            stall_req_o = 1'b1;
          end
        end
      end
      ST_BUS: begin
        stall_req_o = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = r_lanes.we;
        bus_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
        bus_sel_o   = r_lanes.sel;
        bus_wdata_o = r_lanes.wdata;
      end
      ST_DONE: begin
        wd_o = r_wd;
        if (r_flushed) begin
          wreg_o = 1'b0;
        end else if (r_tmo) begin
          exc_o = EXC_BUS;
        end else if (r_aluop == OP_SC) begin
          wreg_o  = r_wreg;
          wdata_o = 32'h1;
        end else begin
          wreg_o  = r_lanes.we ? 1'b0 : r_wreg;
          wdata_o = fmt_ldata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs (big-endian DUT plus a little-endian twin).
module tb_mem_stage_hs;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, wreg, flush, llbit_clr, ack;
  logic [7:0]  aluop;
  logic [31:0] addr, reg2, wdata, rdata;
  logic [4:0]  wd;

  logic [4:0]  wd_o, le_wd_o;
  logic        wreg_o, le_wreg_o, stall, le_stall, llbit_o, le_llbit_o;
  logic [31:0] wdata_o, le_wdata_o, bus_addr, le_bus_addr, bus_wdata, le_bus_wdata;
  logic [1:0]  exc, le_exc;
  logic        bus_req, le_bus_req, bus_we, le_bus_we;
  logic [3:0]  bus_sel, le_bus_sel;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .aluop_i(aluop), .addr_i(addr),
    .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .flush_i(flush),
    .llbit_clr_i(llbit_clr), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall), .exc_o(exc), .llbit_o(llbit_o), .bus_req_o(bus_req),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_sel_o(bus_sel),
    .bus_wdata_o(bus_wdata), .bus_ack_i(ack), .bus_rdata_i(rdata)
  );

  mem_stage_hs #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) dut_le (
    .clk(clk), .reset(reset), .valid_i(valid), .aluop_i(aluop), .addr_i(addr),
    .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata), .flush_i(flush),
    .llbit_clr_i(llbit_clr), .wd_o(le_wd_o), .wreg_o(le_wreg_o), .wdata_o(le_wdata_o),
    .stall_req_o(le_stall), .exc_o(le_exc), .llbit_o(le_llbit_o), .bus_req_o(le_bus_req),
    .bus_we_o(le_bus_we), .bus_addr_o(le_bus_addr), .bus_sel_o(le_bus_sel),
    .bus_wdata_o(le_bus_wdata), .bus_ack_i(ack), .bus_rdata_i(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; aluop = 8'h00; addr = 32'h0; reg2 = 32'h0; wd = 5'd0;
    wreg = 1'b0; wdata = 32'h0; flush = 1'b0; llbit_clr = 1'b0; ack = 1'b0;
    rdata = 32'h0;
  endtask

  task automatic mem_op(input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] r2, input logic [4:0] d);
    valid = 1'b1; aluop = op; addr = a; reg2 = r2; wd = d; wreg = 1'b1; wdata = a;
  endtask

  task automatic count_stall();
    if (stall) stall_cnt++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_llbit", 32'(llbit_o), 32'h0);
    chk("rst_wreg", 32'(wreg_o), 32'h0);
    chk("rst_exc", 32'(exc), 32'h0);
    reset = 1'b0;
    cyc();

    // Non-memory op passes straight through
    valid = 1'b1; aluop = 8'h21; wd = 5'd5; wreg = 1'b1; wdata = 32'hDEADBEEF; #1;
    chk("pt_wdata", wdata_o, 32'hDEADBEEF);
    chk("pt_wreg", 32'(wreg_o), 32'h1);
    chk("pt_wd", 32'(wd_o), 32'd5);
    chk("pt_stall", 32'(stall), 32'h0);
    chk("pt_req", 32'(bus_req), 32'h0);
    cyc();

    // LB at offset 1, ack on the third bus cycle
    stall_cnt = 0;
    mem_op(OP_LB, 32'h0000_1001, 32'h0, 5'd3); #1;
    count_stall();
    chk("lb_req_idle", 32'(bus_req), 32'h0);
    cyc(); count_stall();
    chk("lb_req", 32'(bus_req), 32'h1);
    chk("lb_sel1", 32'(bus_sel), 32'h4);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_we", 32'(bus_we), 32'h0);
    chk("lb_le_sel", 32'(le_bus_sel), 32'h2);
    cyc(); count_stall();
    chk("lb_sel2", 32'(bus_sel), 32'h4);
    cyc(); count_stall();
    chk("lb_sel3", 32'(bus_sel), 32'h4);
    ack = 1'b1; rdata = 32'h1280_3456;
    cyc(); ack = 1'b0; count_stall();
    chk("lb_done_stall", 32'(stall), 32'h0);
    chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
    chk("lb_wreg", 32'(wreg_o), 32'h1);
    chk("lb_wd", 32'(wd_o), 32'd3);
    chk("lb_done_req", 32'(bus_req), 32'h0);
    chk("lb_le_wdata", le_wdata_o, 32'h0000_0034);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    cyc(); idle();

    // SH at offset 2
    mem_op(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 5'd4); #1;
    chk("sh_stall", 32'(stall), 32'h1);
    cyc();
    chk("sh_sel", 32'(bus_sel), 32'h3);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(bus_we), 32'h1);
    chk("sh_addr", bus_addr, 32'h0000_2000);
    chk("sh_le_sel", 32'(le_bus_sel), 32'hC);
    ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("sh_wreg", 32'(wreg_o), 32'h0);
    chk("sh_done_stall", 32'(stall), 32'h0);
    cyc(); idle();

    // Misaligned word load and store
    mem_op(OP_LW, 32'h0000_3002, 32'h0, 5'd6); #1;
    chk("lw_mis_exc", 32'(exc), 32'h1);
    chk("lw_mis_stall", 32'(stall), 32'h0);
    chk("lw_mis_req", 32'(bus_req), 32'h0);
    chk("lw_mis_wreg", 32'(wreg_o), 32'h0);
    aluop = OP_SW; addr = 32'h0000_3001; #1;
    chk("sw_mis_exc", 32'(exc), 32'h2);
    cyc(); idle(); #1;
    chk("mis_req_after", 32'(bus_req), 32'h0);
    chk("mis_exc_after", 32'(exc), 32'h0);

    // LL then successful SC, then failing SC
    mem_op(OP_LL, 32'h0000_4000, 32'h0, 5'd8); #1;
    cyc();
    ack = 1'b1; rdata = 32'h55AA_1234;
    cyc(); ack = 1'b0;
    chk("ll_wdata", wdata_o, 32'h55AA_1234);
    chk("ll_llbit", 32'(llbit_o), 32'h1);
    chk("ll_wreg", 32'(wreg_o), 32'h1);
    cyc();
    mem_op(OP_SC, 32'h0000_4000, 32'h7, 5'd9); #1;
    chk("sc_stall", 32'(stall), 32'h1);
    cyc();
    chk("sc_req", 32'(bus_req), 32'h1);
    chk("sc_we", 32'(bus_we), 32'h1);
    chk("sc_bus_wdata", bus_wdata, 32'h7);
    chk("sc_sel", 32'(bus_sel), 32'hF);
    ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("sc_result", wdata_o, 32'h1);
    chk("sc_llbit", 32'(llbit_o), 32'h0);
    chk("sc_wreg", 32'(wreg_o), 32'h1);
    cyc();
    chk("sc2_wdata", wdata_o, 32'h0);
    chk("sc2_stall", 32'(stall), 32'h0);
    chk("sc2_wreg", 32'(wreg_o), 32'h1);
    cyc();
    chk("sc2_req", 32'(bus_req), 32'h0);
    idle();

    // LL, link cleared, SC fails
    mem_op(OP_LL, 32'h0000_4100, 32'h0, 5'd8); #1;
    cyc(); ack = 1'b1;
    cyc(); ack = 1'b0;
    chk("ll2_llbit", 32'(llbit_o), 32'h1);
    cyc(); idle(); llbit_clr = 1'b1;
    cyc(); llbit_clr = 1'b0;
    chk("clr_llbit", 32'(llbit_o), 32'h0);
    mem_op(OP_SC, 32'h0000_4100, 32'h3, 5'd9); #1;
    chk("scf_wdata", wdata_o, 32'h0);
    chk("scf_stall", 32'(stall), 32'h0);
    cyc();
    chk("scf_req", 32'(bus_req), 32'h0);
    idle();

    // Clear beats an LL completing in the same cycle
    mem_op(OP_LL, 32'h0000_4200, 32'h0, 5'd8); #1;
    cyc(); ack = 1'b1; llbit_clr = 1'b1;
    cyc(); ack = 1'b0; llbit_clr = 1'b0;
    chk("prio_llbit", 32'(llbit_o), 32'h0);
    cyc(); idle();

    // Bus timeout after four request cycles
    mem_op(OP_LW, 32'h0000_5000, 32'h0, 5'd10); #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(bus_req), 32'h1);
      cyc();
    end
    chk("to_req_done", 32'(bus_req), 32'h0);
    chk("to_exc", 32'(exc), 32'h3);
    chk("to_wreg", 32'(wreg_o), 32'h0);
    chk("to_stall", 32'(stall), 32'h0);
    cyc(); idle();

    // Flush while on the bus, then timeout: no exception reported
    mem_op(OP_LW, 32'h0000_5100, 32'h0, 5'd10); #1;
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("fl_req_held", 32'(bus_req), 32'h1);
    cyc(); cyc(); cyc();
    chk("fl_exc", 32'(exc), 32'h0);
    chk("fl_wreg", 32'(wreg_o), 32'h0);
    chk("fl_req", 32'(bus_req), 32'h0);
    cyc(); idle();

    // Flushed LL leaves the link bit alone
    mem_op(OP_LL, 32'h0000_4300, 32'h0, 5'd8); #1;
    cyc(); flush = 1'b1; ack = 1'b1;
    cyc(); flush = 1'b0; ack = 1'b0;
    chk("flll_llbit", 32'(llbit_o), 32'h0);
    chk("flll_wreg", 32'(wreg_o), 32'h0);
    cyc(); idle();

    // Flush in IDLE suppresses the op
    mem_op(OP_LW, 32'h0000_6000, 32'h0, 5'd11); flush = 1'b1; #1;
    chk("fi_stall", 32'(stall), 32'h0);
    chk("fi_wreg", 32'(wreg_o), 32'h0);
    chk("fi_wdata", wdata_o, 32'h0);
    cyc();
    chk("fi_req", 32'(bus_req), 32'h0);
    idle();

    // Reset in BUS drops the request on the next edge
    mem_op(OP_LW, 32'h0000_7000, 32'h0, 5'd12); #1;
    cyc();
    chk("rb_req", 32'(bus_req), 32'h1);
    reset = 1'b1; idle();
    cyc();
    chk("rb_req_after", 32'(bus_req), 32'h0);
    chk("rb_stall_after", 32'(stall), 32'h0);
    reset = 1'b0;
    cyc();
    chk("rb_req_idle", 32'(bus_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
